// File: rtl/poly_byte_encoder_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the
// polynomial ByteEncode_D serialiser.
package poly_byte_encoder_pkg;

  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  // 20-bit accumulator: fetch needs fewer than 8 bits held, so at most 7 + 12 bits are ever live
  localparam int ACC_W  = 20;
  localparam int CNT_W  = 5;
  localparam int COEF_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  function automatic int enc_bytes(input int d);
    return (KYBER_N / 8) * d;
  endfunction

  function automatic bit d_is_legal(input int d);
    return d inside {1, 4, 5, 10, 11, 12};
  endfunction

endpackage

// File: rtl/poly_byte_encoder_packer.sv
// LSB-first bit accumulator: absorbs one D-bit coefficient or releases one
// byte per cycle, never both.
module poly_byte_encoder_packer
  import poly_byte_encoder_pkg::*;
#(
  parameter int D = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [11:0]      coef_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic [7:0]       byte_o
);

  localparam logic [COEF_W-1:0] COEF_MASK = COEF_W'((1 << D) - 1);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] coef_ext;

  // Upper rd_data bits beyond D are don't-care and are masked off here
  assign coef_ext = {{(ACC_W - COEF_W){1'b0}}, coef_i & COEF_MASK};

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      acc_d = acc_q | (coef_ext << cnt_q);
      cnt_d = cnt_q + CNT_W'(D);
    end else if (pop_i) begin
      acc_d = acc_q >> 8;
      cnt_d = cnt_q - CNT_W'(8);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_cnt_o = cnt_q;
  assign byte_o    = acc_q[7:0];

endmodule

// File: rtl/poly_byte_encoder.sv
// ByteEncode_D: reads 256 coefficients from a sync-read poly RAM port and
// streams the 32*D packed bytes out on a valid/ready interface.
module poly_byte_encoder
  import poly_byte_encoder_pkg::*;
#(
  parameter int D = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic        busy,
  output logic        rd_en,
  output logic [7:0]  rd_addr,
  input  logic [11:0] rd_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic [1:0]  dbg_state_o
);

  // Byte handshake: a byte moves when byte_valid & byte_ready on a rising
  // edge; once byte_valid is high, it and byte_data stay unchanged until that
  // transfer happens (no retraction).

  localparam int             NBYTES    = enc_bytes(D);
  localparam logic [8:0]     LAST_BYTE = 9'(NBYTES - 1);

  if (!d_is_legal(D)) begin : g_bad_d
    $error("poly_byte_encoder: D=%0d is not one of 1,4,5,10,11,12", D);
  end

  enc_state_e       state_q;
  logic [8:0]       coef_idx_q;
  logic             rd_pend_q;
  logic [7:0]       rd_addr_q;
  logic [8:0]       byte_cnt_q;

  logic [CNT_W-1:0] acc_cnt;
  logic [7:0]       acc_byte;
  logic             run;
  logic             fetch;
  logic             xfer;
  logic             last_xfer;
  logic             start_acc;

  assign run        = (state_q == ST_RUN);
  assign start_acc  = (state_q == ST_IDLE) && start;
  assign fetch      = run && !rd_pend_q && (acc_cnt < CNT_W'(8)) && !coef_idx_q[8];
  assign byte_valid = run && (acc_cnt >= CNT_W'(8));
  assign xfer       = byte_valid && byte_ready;
  assign last_xfer  = xfer && (byte_cnt_q == LAST_BYTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      coef_idx_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            coef_idx_q <= '0;
            rd_pend_q  <= 1'b0;
            byte_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          rd_pend_q <= fetch;
          if (fetch) begin
            coef_idx_q <= coef_idx_q + 9'd1;
            rd_addr_q  <= coef_idx_q[7:0];
          end
          if (xfer) begin
            byte_cnt_q <= byte_cnt_q + 9'd1;
          end
          // 256*D is a whole number of bytes, so the accumulator is empty here
          if (last_xfer) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  poly_byte_encoder_packer #(.D(D)) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (start_acc),
    .load_i   (rd_pend_q),
    .coef_i   (rd_data),
    .pop_i    (xfer),
    .acc_cnt_o(acc_cnt),
    .byte_o   (acc_byte)
  );

  assign rd_en       = fetch;
  assign rd_addr     = fetch ? coef_idx_q[7:0] : rd_addr_q;
  assign byte_data   = acc_byte;
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_poly_byte_encoder.sv
// Self-checking bench: one encoder per coefficient width, a shared poly RAM
// model and a golden ByteEncode_D feeding an expected-byte queue.
module tb_poly_byte_encoder;

  localparam int NI     = 5;
  localparam int DS[NI] = '{12, 1, 4, 10, 11};
  localparam int BUDGET = 8000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] start_r;
  logic          byte_ready_r;
  logic          done_w       [NI];
  logic          busy_w       [NI];
  logic          rd_en_w      [NI];
  logic          byte_valid_w [NI];
  logic [7:0]    rd_addr_w    [NI];
  logic [7:0]    byte_data_w  [NI];
  logic [1:0]    state_w      [NI];
  logic [11:0]   mem          [256];

  logic [7:0]    exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            sel      = 0;
  bit            mon_en   = 1'b0;
  int            cyc      = 0;
  int            xfer_cnt, done_cnt, rd_viol, last_xfer_cyc, done_cyc;
  bit            hold_pend;
  logic [7:0]    held_data;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs and sync-read RAM model ----------------
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam logic [11:0] DMASK = 12'((1 << DS[g]) - 1);
    logic [11:0] rd_data_l;

    poly_byte_encoder #(.D(DS[g])) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_r[g]),
      .done       (done_w[g]),
      .busy       (busy_w[g]),
      .rd_en      (rd_en_w[g]),
      .rd_addr    (rd_addr_w[g]),
      .rd_data    (rd_data_l),
      .byte_valid (byte_valid_w[g]),
      .byte_data  (byte_data_w[g]),
      .byte_ready (byte_ready_r),
      .dbg_state_o(state_w[g])
    );

    // Junk above bit D-1, and junk on cycles without a read
    always @(posedge clk) begin
      if (rd_en_w[g]) rd_data_l <= mem[rd_addr_w[g]] | (12'($urandom) & ~DMASK);
      else            rd_data_l <= 12'($urandom);
    end
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Golden ByteEncode_D: stream bit s is bit (s % d) of coefficient s / d
  task automatic push_golden(input int d);
    logic [7:0] b;
    int s;
    exp_q.delete();
    for (int k = 0; k < 32 * d; k++) begin
      b = '0;
      for (int bb = 0; bb < 8; bb++) begin
        s = 8 * k + bb;
        b[bb] = mem[s / d][s % d];
      end
      exp_q.push_back(b);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (done_w[sel]) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mon_en) begin
      if (rd_en_w[sel] && byte_valid_w[sel]) rd_viol++;
      if (hold_pend) begin
        check_eq("stall_valid", 32'(byte_valid_w[sel]), 32'd1);
        check_eq("stall_data", 32'(byte_data_w[sel]), 32'(held_data));
      end
      if (byte_valid_w[sel] && byte_ready_r) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) check_eq("byte_extra", 32'(exp_q.size()), 32'd1);
        else check_eq($sformatf("byte%0d_d%0d", xfer_cnt - 1, DS[sel]),
                      32'(byte_data_w[sel]), 32'(exp_q.pop_front()));
        hold_pend = 1'b0;
      end else if (byte_valid_w[sel]) begin
        hold_pend = 1'b1;
        held_data = byte_data_w[sel];
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic check_all_zero(input int s, input string pfx);
    check_eq({pfx, "_done"},  32'(done_w[s]),       32'd0);
    check_eq({pfx, "_busy"},  32'(busy_w[s]),       32'd0);
    check_eq({pfx, "_rd_en"}, 32'(rd_en_w[s]),      32'd0);
    check_eq({pfx, "_addr"},  32'(rd_addr_w[s]),    32'd0);
    check_eq({pfx, "_valid"}, 32'(byte_valid_w[s]), 32'd0);
    check_eq({pfx, "_data"},  32'(byte_data_w[s]),  32'd0);
  endtask

  task automatic run_encode(input int s, input int ready_pct, input bit poke, input int abort_at);
    int n;
    sel = s;
    push_golden(DS[s]);
    xfer_cnt = 0; done_cnt = 0; rd_viol = 0;
    last_xfer_cyc = -1; done_cyc = -100; hold_pend = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    start_r[s]   = 1'b1;
    byte_ready_r = ($urandom_range(0, 99) < ready_pct);
    @(posedge clk); #1;
    start_r[s] = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < BUDGET) begin
      if (abort_at > 0 && xfer_cnt >= abort_at) break;
      byte_ready_r = ($urandom_range(0, 99) < ready_pct);
      start_r[s]   = poke && (done_w[s] || (busy_w[s] && $urandom_range(0, 31) == 0));
      @(posedge clk); #1;
      n++;
    end
    start_r[s] = 1'b0;

    if (abort_at > 0) begin
      mon_en = 1'b0;
      check_eq("abort_point", 32'(xfer_cnt), 32'(abort_at));
      rst_n = 1'b0;
      #1;
      check_all_zero(s, "abort");
      check_eq("abort_state", 32'(state_w[s]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("abort_no_done", 32'(done_cnt), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      return;
    end

    check_eq($sformatf("done_seen_d%0d", DS[s]), 32'(done_cnt), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    check_eq("done_once",    32'(done_cnt),            32'd1);
    check_eq("busy_after",   32'(busy_w[s]),           32'd0);
    check_eq("xfer_count",   32'(xfer_cnt),            32'(32 * DS[s]));
    check_eq("exp_q_empty",  32'(exp_q.size()),        32'd0);
    check_eq("done_latency", 32'(done_cyc - last_xfer_cyc), 32'd1);
    check_eq("rd_vs_valid",  32'(rd_viol),             32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n        = 1'b0;
    start_r      = '0;
    byte_ready_r = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_all_zero(i, $sformatf("reset%0d", i));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // D=12 all zero, then two non-zero coefficients
    run_encode(0, 100, 1'b0, 0);
    mem[0] = 12'h123;
    mem[1] = 12'hABC;
    run_encode(0, 100, 1'b0, 0);

    // D=1 alternating bits, D=4 counting nibbles
    for (int i = 0; i < 256; i++) mem[i] = 12'(i & 1);
    run_encode(1, 100, 1'b0, 0);
    for (int i = 0; i < 256; i++) mem[i] = 12'(i % 16);
    run_encode(2, 100, 1'b0, 0);

    // D=10 random data under heavy back-pressure, stray starts
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 1023));
    run_encode(3, 30, 1'b1, 0);

    // D=11 aborted by reset at byte 100, then a full run
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 2047));
    run_encode(4, 60, 1'b0, 100);
    run_encode(4, 60, 1'b1, 0);

    // D=12 random values below q with back-pressure and stray starts
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom_range(0, 3328));
    run_encode(0, 50, 1'b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
